// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipelined_cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Per-stage control payload: beat-present flag and the group carry handed forward
  typedef struct packed {
    logic vld;
    logic carry;
  } stage_ctl_t;

  // One pipeline stage per lookahead group; width is expected to be a multiple of group
  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// GROUP-bit carry-lookahead slice: sum and carry-out from a, b and carry-in.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module cla_group
  import pipelined_cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             c_out
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   carry;
  logic             term;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Flat lookahead: each carry is an OR of generate terms propagated through the bits above them
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    carry[0] = c_in;
    for (int i = 1; i <= GROUP; i++) begin
      carry[i] = 1'b0;
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & prop[k];
        end
        carry[i] = carry[i] | term;
      end
      term = c_in;
      for (int k = 0; k < i; k++) begin
        term = term & prop[k];
      end
      carry[i] = carry[i] | term;
    end
  end

  assign sum   = prop ^ carry[GROUP-1:0];
  assign c_out = carry[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract, one lookahead group resolved per stage (macro PIPELINED_CLA_ADDER_OVF_EN adds ovf).
// Latency: NUM_GROUPS cycles from the accept edge to out_valid.
// Backpressure: whole pipe stalls (in_ready=0) while out_valid && !out_ready; no bubble collapsing.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S
`ifdef PIPELINED_CLA_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_GROUPS = num_groups(WIDTH, GROUP);
  localparam int LAST       = NUM_GROUPS - 1;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtract is A + ~B + 1, so the incoming carry is forced high and cin is ignored
  assign b_eff = (op == OP_SUB) ? ~B : B;
  assign c_eff = (op == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
    localparam int RESD = (k + 1) * GROUP;  // sum bits resolved after this stage
    localparam int REM  = WIDTH - RESD;     // operand bits still waiting for later stages

    logic [GROUP-1:0] grp_a;
    logic [GROUP-1:0] grp_b;
    logic [GROUP-1:0] grp_sum;
    logic             grp_cin;
    logic             grp_cout;
    logic             vld_in;
    stage_ctl_t       ctl_d;
    stage_ctl_t       ctl_q;
    logic [RESD-1:0]  sum_d;
    logic [RESD-1:0]  sum_q;

    if (k == 0) begin : g_first
      assign grp_a   = A[GROUP-1:0];
      assign grp_b   = b_eff[GROUP-1:0];
      assign grp_cin = c_eff;
      assign vld_in  = in_valid;
      assign sum_d   = grp_sum;
    end else begin : g_next
      assign grp_a   = g_stage[k-1].g_ops.a_q[GROUP-1:0];
      assign grp_b   = g_stage[k-1].g_ops.b_q[GROUP-1:0];
      assign grp_cin = g_stage[k-1].ctl_q.carry;
      assign vld_in  = g_stage[k-1].ctl_q.vld;
      assign sum_d   = {grp_sum, g_stage[k-1].sum_q};
    end

    assign ctl_d = '{vld: vld_in, carry: grp_cout};

    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (grp_a),
      .b     (grp_b),
      .c_in  (grp_cin),
      .sum   (grp_sum),
      .c_out (grp_cout)
    );

    // Valid moves on every enabled edge; data only reloads behind a real beat so S rests on the last result
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q.vld <= ctl_d.vld;
        if (ctl_d.vld) begin
          ctl_q.carry <= ctl_d.carry;
          sum_q       <= sum_d;
        end
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = A[WIDTH-1:GROUP];
        assign b_d = b_eff[WIDTH-1:GROUP];
      end else begin : g_src_stage
        assign a_d = g_stage[k-1].g_ops.a_q[REM+GROUP-1:GROUP];
        assign b_d = g_stage[k-1].g_ops.b_q[REM+GROUP-1:GROUP];
      end

      // Carry the not-yet-resolved operand bits forward with their beat
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && ctl_d.vld) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef PIPELINED_CLA_ADDER_OVF_EN
    if (k == LAST) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit; overflow when it differs from carry-out
      assign ovf_d = (grp_a[GROUP-1] ^ grp_b[GROUP-1] ^ grp_sum[GROUP-1]) ^ grp_cout;

      // Overflow flag travels with the final-stage result
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && ctl_d.vld) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[LAST].ctl_q.vld;
  assign S         = {g_stage[LAST].ctl_q.carry, g_stage[LAST].sum_q};
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

`ifdef PIPELINED_CLA_ADDER_OVF_EN
  assign ovf = g_stage[LAST].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// Directed scenarios plus randomized traffic against an arithmetic reference model.
// Inputs driven on the falling edge, outputs sampled away from the rising edge.
module tb_pipelined_cla_adder;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              op;
  logic              cin;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH:0]    S;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
  logic              ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .cin       (cin),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S)
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Reference: plain integer arithmetic modulo 2^17
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic o, input logic c);
    int unsigned t;
    if (o) t = int'(a) + (32'd65535 - int'(b)) + 1;
    else   t = int'(a) + int'(b) + int'(c);
    return t[WIDTH:0];
  endfunction

  // Reference: signed result out of 16-bit two's-complement range
  function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic o, input logic c);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (o) r = sa - sb;
    else   r = sa + sb + int'(c);
    return (r > 32767) || (r < -32768);
  endfunction

  // Issue one beat into an idle pipe and report how many edges until out_valid (-1 = never)
  task automatic run_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic o,
                         input logic c, output int lat, output logic [WIDTH:0] s, output logic ov);
    @(negedge clk);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    op        = o;
    cin       = c;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    s   = '0;
    ov  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid === 1'b1) begin
        lat = n;
        s   = S;
`ifdef PIPELINED_CLA_ADDER_OVF_EN
        ov  = ovf;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    A         = 16'h00FF;
    B         = 16'h0F0F;
    op        = 1'b0;
    cin       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (S !== '0) begin
        failures++;
        $display("FAIL reset_S got=%h exp=00000", S);
      end
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_ghost cycle=%0d got=%b exp=0", i, out_valid);
      end
    end
  endtask

  task automatic test_add_latency();
    int lat;
    logic [WIDTH:0] s;
    logic ov;
    run_one(16'h0001, 16'h0001, 1'b0, 1'b0, lat, s, ov);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=%0d", lat, LAT);
    end
    checks++;
    if (s !== ref_sum(16'h0001, 16'h0001, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL add_S got=%h exp=%h", s, ref_sum(16'h0001, 16'h0001, 1'b0, 1'b0));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_drop_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    logic [WIDTH:0] s;
    logic ov;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, ov);
    checks++;
    if (s !== ref_sum(16'hFFFF, 16'h0001, 1'b0, 1'b0) || lat !== LAT) begin
      failures++;
      $display("FAIL chain_ffff_1 got=%h lat=%0d exp=%h lat=%0d", s, lat,
               ref_sum(16'hFFFF, 16'h0001, 1'b0, 1'b0), LAT);
    end
    run_one(16'hFFFF, 16'h0000, 1'b0, 1'b1, lat, s, ov);
    checks++;
    if (s !== ref_sum(16'hFFFF, 16'h0000, 1'b0, 1'b1) || lat !== LAT) begin
      failures++;
      $display("FAIL chain_ffff_cin got=%h lat=%0d exp=%h lat=%0d", s, lat,
               ref_sum(16'hFFFF, 16'h0000, 1'b0, 1'b1), LAT);
    end
  endtask

  task automatic test_subtract();
    int lat;
    logic [WIDTH:0] s;
    logic ov;
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, lat, s, ov);
    checks++;
    if (s !== ref_sum(16'h0005, 16'h0007, 1'b1, 1'b1) || lat !== LAT) begin
      failures++;
      $display("FAIL sub_5_7 got=%h lat=%0d exp=%h", s, lat, ref_sum(16'h0005, 16'h0007, 1'b1, 1'b1));
    end
    run_one(16'h0009, 16'h0009, 1'b1, 1'b0, lat, s, ov);
    checks++;
    if (s !== ref_sum(16'h0009, 16'h0009, 1'b1, 1'b0) || lat !== LAT) begin
      failures++;
      $display("FAIL sub_9_9 got=%h lat=%0d exp=%h", s, lat, ref_sum(16'h0009, 16'h0009, 1'b1, 1'b0));
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] got[$];
    logic [WIDTH:0] exp[$];
    int seen;
    exp.push_back(ref_sum(16'h0001, 16'h0001, 1'b0, 1'b0));
    exp.push_back(ref_sum(16'h0002, 16'h0002, 1'b0, 1'b0));
    exp.push_back(ref_sum(16'h0004, 16'h0004, 1'b0, 1'b0));
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 1'b0;
    cin       = 1'b0;
    A = 16'h0001; B = 16'h0001;
    @(negedge clk);
    A = 16'h0002; B = 16'h0002;
    @(negedge clk);
    A = 16'h0004; B = 16'h0004;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen == 0) begin
      failures++;
      $display("FAIL bp_first_valid got=timeout exp=out_valid");
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d in_ready=%b out_valid=%b exp in_ready=0 out_valid=1",
                 i, in_ready, out_valid);
      end
      checks++;
      if (S !== exp[0]) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%h exp=%h", i, S, exp[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (out_valid === 1'b1) got.push_back(S);
      @(negedge clk);
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 1'b0;
    cin       = 1'b0;
    A = 16'h1234; B = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_leak cycle=%0d got=%b exp=0 S=%h", i, out_valid, S);
      end
    end
  endtask

`ifdef PIPELINED_CLA_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    logic [WIDTH:0] s;
    logic ov;
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, ov);
    checks++;
    if (s !== ref_sum(16'h7FFF, 16'h0001, 1'b0, 1'b0) || ov !== ref_ovf(16'h7FFF, 16'h0001, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL ovf_7fff_1 got S=%h ovf=%b exp S=%h ovf=%b", s, ov,
               ref_sum(16'h7FFF, 16'h0001, 1'b0, 1'b0), ref_ovf(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    end
    run_one(16'h8000, 16'h0001, 1'b1, 1'b0, lat, s, ov);
    checks++;
    if (ov !== ref_ovf(16'h8000, 16'h0001, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL ovf_8000_sub1 got=%b exp=%b", ov, ref_ovf(16'h8000, 16'h0001, 1'b1, 1'b0));
    end
    run_one(16'h0002, 16'h0003, 1'b0, 1'b0, lat, s, ov);
    checks++;
    if (ov !== ref_ovf(16'h0002, 16'h0003, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL ovf_2_3 got=%b exp=%b", ov, ref_ovf(16'h0002, 16'h0003, 1'b0, 1'b0));
    end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH+1:0] q[$];
    logic [WIDTH+1:0] e;
    logic [WIDTH:0]   prev_s;
    logic             stalled;
    int sent;
    int done;
    sent    = 0;
    done    = 0;
    stalled = 1'b0;
    prev_s  = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      A         = 16'($urandom);
      B         = 16'($urandom);
      op        = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || S !== prev_s) begin
          failures++;
          $display("FAIL rand_stall_hold cyc=%0d out_valid=%b S=%h exp valid=1 S=%h", cyc, out_valid, S, prev_s);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious cyc=%0d got S=%h exp=no beat", cyc, S);
        end else begin
          e = q.pop_front();
`ifdef PIPELINED_CLA_ADDER_OVF_EN
          if (S !== e[WIDTH:0] || ovf !== e[WIDTH+1]) begin
            failures++;
            $display("FAIL rand_result cyc=%0d got S=%h ovf=%b exp S=%h ovf=%b", cyc, S, ovf, e[WIDTH:0], e[WIDTH+1]);
          end
`else
          if (S !== e[WIDTH:0]) begin
            failures++;
            $display("FAIL rand_result cyc=%0d got S=%h exp S=%h", cyc, S, e[WIDTH:0]);
          end
`endif
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back({ref_ovf(A, B, op, cin), ref_sum(A, B, op, cin)});
        sent++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      prev_s  = S;
      if (sent == 300 && q.size() == 0) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done == 0) begin
      failures++;
      $display("FAIL rand_drain got sent=%0d pending=%0d exp sent=300 pending=0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_carry_chain();
    test_subtract();
    test_backpressure();
    test_mid_reset();
`ifdef PIPELINED_CLA_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 4-bit lookahead adder.
- Operands of WIDTH bits are split into lookahead groups of GROUP bits. One group is resolved per pipeline stage, and its group carry is registered into the next stage.
- A valid/ready handshake on both sides gives full throughput (one op per cycle) with backpressure.
- Sits between operand sources (register file, accumulators) and downstream datapath consumers.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; stage count NUM_GROUPS = WIDTH/GROUP (derived localparam).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- op  in  1  0 = add (A+B+cin), 1 = subtract (A+~B+1; cin ignored)
- cin  in  1  carry-in for add
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- S  out  WIDTH+1  result; S[WIDTH] = carry-out (for subtract, 1 = no borrow)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values: out_valid=0, S=0, all stage valid bits=0, all stage data=0.
- Reset mid-operation discards every in-flight beat. in_ready=1 in the first cycle after rst_n is released.
- Global pipeline enable: adv = !out_valid || out_ready; in_ready = adv.
- No bubble collapsing: when out_valid && !out_ready, the whole pipe holds and in_ready=0.
- Accept: a beat is accepted on a rising edge where in_valid && in_ready.
- Stage 0, at the accept edge:
  - computes effective B (op ? ~B : B) and effective carry (op ? 1 : cin);
  - resolves group 0 through the lookahead unit;
  - registers sum bits [GROUP-1:0], group carry, and the remaining unresolved operand bits.
- Stage k, on each adv edge: resolves group k from the registered operand slice and the incoming carry; registers accumulated sum bits, new carry, and the remaining operand bits.
- Final stage: registers S = {carry_out, sum}.
- Latency: out_valid rises after the NUM_GROUPS-th adv edge, counting the accept edge as edge 1. WIDTH=16, GROUP=4 gives 4 cycles; NUM_GROUPS=1 gives a single registered stage.
- Throughput: 1 beat per cycle when out_ready is held high. Order is preserved.
- S holds stable while out_valid && !out_ready.
- A beat is consumed on an edge with out_valid && out_ready. out_valid drops only if no beat advances into the output stage on that edge.
- Bubbles: stage valid bits propagate with data; an empty stage never produces out_valid.
- Arithmetic is modulo 2^(WIDTH+1). All sum and carry bits are exact; there is no saturation.

Optional Feature:
- Macro: PIPELINED_CLA_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered alongside S with the same valid timing;
  - ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB, using effective B;
  - ovf reset value 0.
- Undefined: port ovf is absent and no overflow logic is generated.

Decomposition:
- Package pipelined_cla_pkg:
  - OP_ADD/OP_SUB constants;
  - function num_groups(WIDTH, GROUP);
  - stage payload typedef if SystemVerilog is used.
- Sub-module cla_group:
  - combinational GROUP-bit lookahead with generate/propagate terms;
  - inputs a, b, c_in; outputs sum[GROUP-1:0], c_out;
  - instantiated once per stage via generate.

Test Plan (WIDTH=16, GROUP=4):
- Reset with rst_n=0 for 2 cycles while in_valid=1: out_valid=0 and S=0 throughout; after release, in_ready=1 and nothing emerges from the pre-reset beats.
- Add 0x0001+0x0001, cin=0, out_ready=1: exactly 4 cycles after accept, out_valid=1 and S=0x00002.
- Full carry chain: 0xFFFF+0x0001, cin=0 → S=0x10000. Also 0xFFFF+0x0000, cin=1 → S=0x10000.
- Subtract: 0x0005−0x0007 (op=1, cin=1 ignored) → S=0x0FFFE (borrow, bit16=0). Subtract 0x0009−0x0009 → S=0x10000.
- Backpressure: send 3 back-to-back beats (1+1, 2+2, 4+4); hold out_ready=0 for 3 cycles once out_valid=1:
  - in_ready=0 while stalled and S held at 0x00002;
  - after release, results 0x00002, 0x00004, 0x00008 appear in order with none lost or duplicated.
- Reset mid-flight, plus the overflow macro if defined:
  - assert rst_n=0 two cycles after accepting 0x1234+0x1111: no output emerges;
  - with PIPELINED_CLA_ADDER_OVF_EN defined, 0x7FFF+0x0001 → S=0x08000, ovf=1; 0x8000−0x0001 → ovf=1; 0x0002+0x0003 → ovf=0.
